// File: rtl/psr_write_sequencer.sv
// psr_write_sequencer: owns the 65C02 status register P and arbitrates all
// writes into it (PLP load, single-bit flag ops, ALU flags, interrupt entry,
// SO pin). Interrupt entry pushes P to the stack unit, then sets I / clears D.
// Optional feature macro: PSR_SO_PIN_EN (SO pin synchroniser and edge detect).
//
// state | meaning
// IDLE  | grants one requester per cycle by fixed priority
// PUSH  | presenting captured P image to the stack unit, waiting for ready
// SETI  | set I, clear D, apply any pended SO edge, pulse int_ack
module psr_write_sequencer (
  input  logic       fclk,
  input  logic       reset,
  input  logic [7:0] db_in,
  input  logic       plp_req,
  output logic       plp_ack,
  input  logic       alu_req,
  output logic       alu_ack,
  input  logic [3:0] alu_mask,
  input  logic       alu_n,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       flag_req,
  output logic       flag_ack,
  input  logic [2:0] flag_sel,
  input  logic       flag_val,
  input  logic       int_req,
  output logic       int_ack,
  input  logic       int_brk,
  output logic       push_valid,
  input  logic       push_ready,
  output logic [7:0] push_data,
  input  logic       sob_n,
  output logic [7:0] p_out,
  output logic       c_carry,
  output logic       d_decimal,
  output logic       i_mask
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PUSH = 2'd1;
  localparam logic [1:0] SETI = 2'd2;

  logic [1:0] state_q, state_d;
  logic       n_q, v_q, d_q, i_q, z_q, c_q;
  logic       n_d, v_d, d_d, i_d, z_d, c_d;
  logic       plp_ack_q, alu_ack_q, flag_ack_q, int_ack_q;
  logic       plp_ack_d, alu_ack_d, flag_ack_d, int_ack_d;
  logic [7:0] push_data_q, push_data_d;
  logic       so_edge;

  // A requester whose ack is currently high is still holding req; mask it.
  logic int_go, plp_go, flag_go, alu_go;
  assign int_go  = int_req  & ~int_ack_q;
  assign plp_go  = plp_req  & ~plp_ack_q;
  assign flag_go = flag_req & ~flag_ack_q;
  assign alu_go  = alu_req  & ~alu_ack_q;

`ifdef PSR_SO_PIN_EN
  logic sob_meta_q, sob_sync_q, sob_prev_q;
  logic so_pend_q, so_pend_d;

  // Two-flop synchroniser plus previous-value register for fall detection.
  always_ff @(posedge fclk) begin
    if (reset) begin
      sob_meta_q <= 1'b1;
      sob_sync_q <= 1'b1;
      sob_prev_q <= 1'b1;
      so_pend_q  <= 1'b0;
    end else begin
      sob_meta_q <= sob_n;
      sob_sync_q <= sob_meta_q;
      sob_prev_q <= sob_sync_q;
      so_pend_q  <= so_pend_d;
    end
  end

  assign so_edge = sob_prev_q & ~sob_sync_q;
`else
  logic unused_sob;
  assign unused_sob = sob_n;
  assign so_edge    = 1'b0;
`endif

  // Next-state: FSM, prioritised P write port and SO forcing of V.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    v_d         = v_q;
    d_d         = d_q;
    i_d         = i_q;
    z_d         = z_q;
    c_d         = c_q;
    plp_ack_d   = 1'b0;
    alu_ack_d   = 1'b0;
    flag_ack_d  = 1'b0;
    int_ack_d   = 1'b0;
    push_data_d = push_data_q;
`ifdef PSR_SO_PIN_EN
    so_pend_d   = so_pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (int_go) begin
          state_d     = PUSH;
          push_data_d = {n_q, v_q, 1'b1, int_brk, d_q, i_q, z_q, c_q};
        end else if (plp_go) begin
          n_d       = db_in[7];
          v_d       = db_in[6];
          d_d       = db_in[3];
          i_d       = db_in[2];
          z_d       = db_in[1];
          c_d       = db_in[0];
          plp_ack_d = 1'b1;
        end else if (flag_go) begin
          case (flag_sel)
            3'd0:    c_d = flag_val;
            3'd1:    z_d = flag_val;
            3'd2:    i_d = flag_val;
            3'd3:    d_d = flag_val;
            3'd6:    v_d = flag_val;
            3'd7:    n_d = flag_val;
            default: ;
          endcase
          flag_ack_d = 1'b1;
        end else if (alu_go) begin
          if (alu_mask[3]) n_d = alu_n;
          if (alu_mask[2]) v_d = alu_v;
          if (alu_mask[1]) z_d = alu_z;
          if (alu_mask[0]) c_d = alu_c;
          alu_ack_d = 1'b1;
        end
      end
      PUSH: begin
        if (push_ready) state_d = SETI;
      end
      SETI: begin
        i_d       = 1'b1;
        d_d       = 1'b0;
        int_ack_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // SO edge wins over any same-cycle V write; held back while pushing.
`ifdef PSR_SO_PIN_EN
    if (so_edge) begin
      if (state_q == PUSH) so_pend_d = 1'b1;
      else                 v_d = 1'b1;
    end
    if (state_q == SETI && so_pend_q) begin
      v_d       = 1'b1;
      so_pend_d = 1'b0;
    end
`else
    if (so_edge) v_d = 1'b1;
`endif
  end

  // State registers with synchronous reset to P = 8'h34.
  always_ff @(posedge fclk) begin
    if (reset) begin
      state_q     <= IDLE;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      d_q         <= 1'b0;
      i_q         <= 1'b1;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      plp_ack_q   <= 1'b0;
      alu_ack_q   <= 1'b0;
      flag_ack_q  <= 1'b0;
      int_ack_q   <= 1'b0;
      push_data_q <= 8'h34;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      v_q         <= v_d;
      d_q         <= d_d;
      i_q         <= i_d;
      z_q         <= z_d;
      c_q         <= c_d;
      plp_ack_q   <= plp_ack_d;
      alu_ack_q   <= alu_ack_d;
      flag_ack_q  <= flag_ack_d;
      int_ack_q   <= int_ack_d;
      push_data_q <= push_data_d;
    end
  end

  assign plp_ack    = plp_ack_q;
  assign alu_ack    = alu_ack_q;
  assign flag_ack   = flag_ack_q;
  assign int_ack    = int_ack_q;
  assign push_valid = (state_q == PUSH);
  assign push_data  = push_data_q;
  assign p_out      = {n_q, v_q, 2'b11, d_q, i_q, z_q, c_q};
  assign c_carry    = c_q;
  assign d_decimal  = d_q;
  assign i_mask     = i_q;

endmodule

// File: tb/tb_psr_write_sequencer.sv
// Scoreboard bench for psr_write_sequencer: the driver updates a byte-level
// model of P and queues the expected acks / push images; a negedge monitor
// pops and compares whenever the DUT shows an ack or a push handshake.
module tb_psr_write_sequencer;

  logic       fclk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] db_in = 8'h00;
  logic       plp_req = 1'b0, alu_req = 1'b0, flag_req = 1'b0, int_req = 1'b0;
  logic       plp_ack, alu_ack, flag_ack, int_ack;
  logic [3:0] alu_mask = 4'h0;
  logic       alu_n = 1'b0, alu_v = 1'b0, alu_z = 1'b0, alu_c = 1'b0;
  logic [2:0] flag_sel = 3'd0;
  logic       flag_val = 1'b0;
  logic       int_brk = 1'b0;
  logic       push_valid, push_ready = 1'b0;
  logic [7:0] push_data, p_out;
  logic       sob_n = 1'b1;
  logic       c_carry, d_decimal, i_mask;

  psr_write_sequencer dut (
    .fclk(fclk), .reset(reset), .db_in(db_in),
    .plp_req(plp_req), .plp_ack(plp_ack),
    .alu_req(alu_req), .alu_ack(alu_ack), .alu_mask(alu_mask),
    .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z), .alu_c(alu_c),
    .flag_req(flag_req), .flag_ack(flag_ack), .flag_sel(flag_sel), .flag_val(flag_val),
    .int_req(int_req), .int_ack(int_ack), .int_brk(int_brk),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .sob_n(sob_n), .p_out(p_out),
    .c_carry(c_carry), .d_decimal(d_decimal), .i_mask(i_mask)
  );

  always #5 fclk = ~fclk;

`ifdef PSR_SO_PIN_EN
  localparam bit SO_EN = 1'b1;
`else
  localparam bit SO_EN = 1'b0;
`endif

  typedef struct {
    bit         is_push;
    logic [3:0] acks;   // {int, plp, flag, alu}
    logic [7:0] val;    // expected p_out after ack, or push_data
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] p_m = 8'h34;
  logic [7:0] push_hold = 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ackv();
    return {int_ack, plp_ack, flag_ack, alu_ack};
  endfunction

  // Monitor: every ack cycle or push handshake consumes one expectation.
  always @(negedge fclk) begin
    if (!reset) begin
      if (push_valid) check("push_data_stable", push_data, push_hold);
      if (push_valid && push_ready) begin
        if (sb.size() == 0) check("unexpected_push", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("push_kind", e.is_push, 1);
          check("push_data", push_data, e.val);
        end
      end
      if (ackv() != 4'b0000) begin
        if (sb.size() == 0) check("unexpected_ack", ackv(), 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("ack_kind", {e.is_push, ackv()}, {1'b0, e.acks});
          check("p_out", p_out, e.val);
          check("flag_outs", {c_carry, d_decimal, i_mask}, {e.val[0], e.val[3], e.val[2]});
        end
      end
    end
  end

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic wait_ack(input int idx, input string nm);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!ackv()[idx] && n < 20);
    if (!ackv()[idx]) check({nm, "_timeout"}, 0, 1);
  endtask

  task automatic exp_ack(input logic [3:0] a, input logic [7:0] v);
    exp_t e;
    e.is_push = 1'b0;
    e.acks    = a;
    e.val     = v;
    sb.push_back(e);
  endtask

  function automatic logic [7:0] alu_model(input logic [7:0] p, input logic [3:0] m,
                                           input logic n, input logic v,
                                           input logic z, input logic c);
    logic [7:0] r;
    r = p;
    if (m[3]) r[7] = n;
    if (m[2]) r[6] = v;
    if (m[1]) r[1] = z;
    if (m[0]) r[0] = c;
    return r;
  endfunction

  task automatic do_plp(input logic [7:0] d);
    p_m = d | 8'h30;
    exp_ack(4'b0100, p_m);
    db_in = d;
    plp_req = 1'b1;
    wait_ack(2, "plp");
    plp_req = 1'b0;
  endtask

  task automatic do_flag(input logic [2:0] sel, input logic val);
    if (sel != 3'd4 && sel != 3'd5) p_m[sel] = val;
    exp_ack(4'b0010, p_m);
    flag_sel = sel;
    flag_val = val;
    flag_req = 1'b1;
    wait_ack(1, "flag");
    flag_req = 1'b0;
  endtask

  task automatic do_alu(input logic [3:0] m, input logic n, input logic v,
                        input logic z, input logic c);
    p_m = alu_model(p_m, m, n, v, z, c);
    exp_ack(4'b0001, p_m);
    {alu_mask, alu_n, alu_v, alu_z, alu_c} = {m, n, v, z, c};
    alu_req = 1'b1;
    wait_ack(0, "alu");
    alu_req = 1'b0;
  endtask

  task automatic do_plp_alu(input logic [7:0] d, input logic [3:0] m, input logic n,
                            input logic v, input logic z, input logic c);
    p_m = d | 8'h30;
    exp_ack(4'b0100, p_m);
    p_m = alu_model(p_m, m, n, v, z, c);
    exp_ack(4'b0001, p_m);
    db_in = d;
    {alu_mask, alu_n, alu_v, alu_z, alu_c} = {m, n, v, z, c};
    plp_req = 1'b1;
    alu_req = 1'b1;
    wait_ack(2, "plp_pair");
    plp_req = 1'b0;
    wait_ack(0, "alu_pair");
    alu_req = 1'b0;
  endtask

  // Interrupt entry; optionally drops sob_n while the push is stalled.
  task automatic do_int(input logic brk, input int delay, input bit so_fall);
    exp_t e;
    int   n = 0;
    push_hold = {p_m[7:6], 1'b1, brk, p_m[3:0]};
    e.is_push = 1'b1;
    e.acks    = 4'b0000;
    e.val     = push_hold;
    sb.push_back(e);
    p_m = (p_m | 8'h04) & 8'hF7;
    if (so_fall && SO_EN) p_m[6] = 1'b1;
    exp_ack(4'b1000, p_m);
    int_brk = brk;
    int_req = 1'b1;
    do begin
      tick();
      n++;
    end while (!push_valid && n < 20);
    if (!push_valid) check("push_valid_timeout", 0, 1);
    if (so_fall) sob_n = 1'b0;
    repeat (delay) tick();
    push_ready = 1'b1;
    tick();
    push_ready = 1'b0;
    wait_ack(3, "int");
    int_req = 1'b0;
    if (so_fall) begin
      sob_n = 1'b1;
      repeat (4) tick();
    end
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    @(negedge fclk);
    check("reset_p_out", p_out, 8'h34);
    check("reset_acks", ackv(), 4'b0000);
    check("reset_push_valid", push_valid, 1'b0);

    do_alu(4'b1011, 1'b1, 1'b1, 1'b0, 1'b1);
    check("alu_directed_model", p_m, 8'hB5);
    do_plp_alu(8'hC3, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0);
    do_plp(8'h3D);
    do_int(1'b1, 2, 1'b0);
    check("int_directed_model", p_m, 8'h35);
    do_flag(3'd6, 1'b0);
    do_flag(3'd4, 1'b0);
    do_flag(3'd5, 1'b1);
    do_int(1'b0, 5, 1'b1);

    do_flag(3'd6, 1'b0);
    sob_n = 1'b0;
    repeat (4) tick();
    if (SO_EN) p_m[6] = 1'b1;
    check("so_idle_v", p_out[6], p_m[6]);
    sob_n = 1'b1;
    repeat (4) tick();

    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 3))
        0: do_plp(8'($urandom));
        1: do_flag(3'($urandom), 1'($urandom));
        2: do_alu(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        default: do_int(1'($urandom), $urandom_range(0, 3), 1'b0);
      endcase
      if ($urandom_range(0, 3) == 0) tick();
    end

    // Reset while the push is pending: no int_ack, P back to 8'h34.
    push_hold = {p_m[7:6], 1'b1, 1'b0, p_m[3:0]};
    int_brk = 1'b0;
    int_req = 1'b1;
    repeat (2) tick();
    check("pre_reset_push_valid", push_valid, 1'b1);
    reset = 1'b1;
    int_req = 1'b0;
    tick();
    check("reset_mid_push_valid", push_valid, 1'b0);
    check("reset_mid_p_out", p_out, 8'h34);
    check("reset_mid_acks", ackv(), 4'b0000);
    reset = 1'b0;
    p_m = 8'h34;
    repeat (3) tick();
    do_alu(4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);

    repeat (5) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/psr_write_sequencer.md
# psr_write_sequencer

Owns the 65C02 processor status register (P) and arbitrates every write into it. Requesters are the ALU flag update, PLP data-bus load, single-bit flag instructions, interrupt/BRK entry and the SO pin. Each requester gets a req/ack handshake. Interrupt entry runs as a sequence: push P to the stack unit, then set I and clear D. The block replaces ad-hoc flag latching with one clocked, prioritised write port between instruction decode, ALU and stack logic.

## Interface
- none (no parameters)

- fclk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- db_in  in  8  PLP source data
- plp_req / plp_ack  in / out  1  PLP load handshake
- alu_req / alu_ack  in / out  1  ALU flag update handshake
- alu_mask  in  4  {n,v,z,c} per-flag write enables
- alu_n, alu_v, alu_z, alu_c  in  1  ALU flag results
- flag_req / flag_ack  in / out  1  single-bit set/clear (SEC/CLC/SED/CLD/SEI/CLI/CLV)
- flag_sel  in  3  bit index into P
- flag_val  in  1  value written
- int_req / int_ack  in / out  1  interrupt-entry sequence
- int_brk  in  1  1 = BRK (pushed B=1), 0 = IRQ/NMI (pushed B=0)
- push_valid  out  1  P push data valid to stack unit
- push_ready  in  1  stack unit accepts push
- push_data  out  8  P image to push
- sob_n  in  1  SO pin, active-low, asynchronous
- p_out  out  8  current P {N,V,1,1,D,I,Z,C}
- c_carry, d_decimal, i_mask  out  1  P[0], P[3], P[2]

Clock is fclk; reset is synchronous and active-high.

## Operation
- P bits 5 and 4 are not stored. p_out[5:4] is always 2'b11.
- Reset values:
  - P = 8'h34 (I=1, D=0, N=V=Z=C=0).
  - All acks and push_valid = 0; FSM = IDLE.
  - SO synchroniser flops = 1, so no spurious edge after reset.
- FSM states:
  - IDLE. If int_req is high, go to PUSH.
  - PUSH. push_valid=1. push_data = {N,V,1,int_brk,D,I,Z,C}, captured on entry and held stable. When push_valid && push_ready, go to SETI.
  - SETI. Set I=1, clear D=0, pulse int_ack, return to IDLE.
- Grants happen only in IDLE, one per cycle. Fixed priority, highest first:
  1. int_req (starts the sequence; no P write that cycle)
  2. plp_req: P ← db_in, bits 5:4 ignored
  3. flag_req: P[flag_sel] ← flag_val; flag_sel 4 or 5 is a no-op but is still acked
  4. alu_req: each flag enabled in alu_mask takes its alu_* value
- Handshake rules:
  - Requesters hold req high until they see ack.
  - ack is a registered one-cycle pulse, high in the cycle after the grant edge.
  - A source whose ack is currently high is not re-granted that cycle. This prevents a double write.
  - While in PUSH or SETI, plp/flag/alu requests stall (no ack).
- SO pin:
  - sob_n passes through a 2-flop synchroniser.
  - Falling edge (previous 1, current 0) sets V=1.
  - V forcing takes precedence over any same-cycle V write from plp/flag/alu.
  - An SO edge in PUSH is held in so_pend and applied in SETI, so push_data never changes mid-handshake.

## Timing
- Grant-to-visible latency: P changes at the grant edge and is visible on p_out the next cycle, together with the ack.
- Interrupt latency:
  - int_req sampled → push_valid high next cycle.
  - Completion is 1 cycle after push_ready handshake, plus 1 cycle in SETI.
  - Minimum int_req-to-int_ack is 3 cycles.
- push_valid stays high until push_ready is seen. It never drops without a handshake except on reset.
- SO latency: sob_n fall to V=1 is 3 cycles (2 sync + edge register), or the SETI cycle if the edge is pended.
- Reset mid-sequence: FSM returns to IDLE, push_valid=0, so_pend=0, P=8'h34. A held int_req restarts the sequence after reset deasserts.

## Configuration
- PSR_SO_PIN_EN
  - Defined: SO synchroniser, edge detect and so_pend are compiled in as above.
  - Undefined: sob_n is ignored, V changes only via plp/flag/alu, and no SO flops exist.

## Test plan
- Reset, then idle → p_out=8'h34, all acks 0, push_valid 0.
- alu_req with mask=4'b1011, n=1, v=1, z=0, c=1 from P=8'h34 → alu_ack next cycle, p_out=8'hB5 (V unchanged at 0).
- plp_req and alu_req asserted together, db_in=8'hC3 → plp_ack first, p_out=8'hF3. alu_ack follows one cycle later and applies on top of 8'hF3.
- int_req, int_brk=1, P=8'h3D, push_ready held low 2 cycles → push_data=8'h3D held stable while waiting. After the handshake, p_out=8'h35 and int_ack pulses once.
- PSR_SO_PIN_EN: sob_n 1→0 while in PUSH → push_data keeps V=0, V=1 appears after SETI. Same edge with PSR_SO_PIN_EN undefined → V stays 0.
- reset asserted in PUSH state → next cycle push_valid=0, p_out=8'h34, no int_ack emitted.
